// File: rtl/decision_pkg.sv
// Shared types and defaults for the decision filter.
// Holds the filter state enum, the "no class" code and default parameters.
package decision_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    LOCKED
  } state_t;

  localparam int CLASS_NONE      = 0;
  localparam int DEF_NUM_CLASSES = 4;
  localparam int DEF_THRESHOLD   = 15;
  localparam int DEF_CNT_W       = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating run counter: clear > load-1 > increment, stops at limit.
// Ports: clock, resetn, clr, load1, inc, limit[CNT_W], count[CNT_W].
module sat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clr,
  input  logic             load1,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load1) begin
      count <= CNT_W'(1);
    end else if (inc && (count < limit)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/decision_filter.sv
// Declares a class after THRESHOLD consecutive matching detector samples.
// Ports: clock, resetn, clear, in_done, in_class -> final_class,
// final_valid, final_new, run_count. Macro DECISION_FILTER_HYST_EN
// holds a lock while a challenger class builds its own run.
module decision_filter
  import decision_pkg::*;
#(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int THRESHOLD   = DEF_THRESHOLD,
  parameter int CNT_W       = DEF_CNT_W,
  localparam int CLASS_W    = $clog2(NUM_CLASSES + 1)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               clear,
  input  logic               in_done,
  input  logic [CLASS_W-1:0] in_class,
  output logic [CLASS_W-1:0] final_class,
  output logic               final_valid,
  output logic               final_new,
  output logic [CNT_W-1:0]   run_count
);

  if (THRESHOLD < 1 || THRESHOLD > (2**CNT_W) - 1) begin : g_bad_thr
    $error("decision_filter: THRESHOLD out of range for CNT_W");
  end

  localparam logic [CLASS_W-1:0] NONE   = CLASS_W'(CLASS_NONE);
  localparam logic [CLASS_W-1:0] MAX_C  = CLASS_W'(NUM_CLASSES);
  localparam logic [CNT_W-1:0]   THR    = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0]   THR_M1 = CNT_W'(THRESHOLD - 1);
  localparam logic               THR_ONE = (THRESHOLD == 1);

  state_t               state, state_n;
  logic [CLASS_W-1:0]   cand, cand_n;
  logic [CLASS_W-1:0]   fclass_n;
  logic                 fvalid_n;
  logic                 fnew_n;
  logic                 cnt_clr;
  logic                 cnt_ld;
  logic                 cnt_inc;
  logic                 sample_ok;
  logic                 at_edge;

  assign sample_ok = (in_class != NONE) && (in_class <= MAX_C);
  // The matching sample about to be counted is the THRESHOLD-th.
  assign at_edge   = (run_count == THR_M1);

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clock (clock),
    .resetn(resetn),
    .clr   (cnt_clr),
    .load1 (cnt_ld),
    .inc   (cnt_inc),
    .limit (THR),
    .count (run_count)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cand        <= NONE;
      final_class <= NONE;
      final_valid <= 1'b0;
      final_new   <= 1'b0;
    end else begin
      state       <= state_n;
      cand        <= cand_n;
      final_class <= fclass_n;
      final_valid <= fvalid_n;
      final_new   <= fnew_n;
    end
  end

  always_comb begin
    state_n  = state;
    cand_n   = cand;
    fclass_n = final_class;
    fvalid_n = final_valid;
    fnew_n   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_ld   = 1'b0;
    cnt_inc  = 1'b0;
    if (clear) begin
      state_n  = IDLE;
      cand_n   = NONE;
      fclass_n = NONE;
      fvalid_n = 1'b0;
      cnt_clr  = 1'b1;
    end else if (in_done) begin
      unique case (state)
        IDLE: begin
          if (sample_ok) begin
            cand_n = in_class;
            cnt_ld = 1'b1;
            if (THR_ONE) begin
              state_n  = LOCKED;
              fclass_n = in_class;
              fvalid_n = 1'b1;
              fnew_n   = 1'b1;
            end else begin
              state_n = TRACK;
            end
          end
        end
        TRACK: begin
          if (!sample_ok) begin
            state_n = IDLE;
            cand_n  = NONE;
            cnt_clr = 1'b1;
          end else if (in_class == cand) begin
            cnt_inc = 1'b1;
            if (at_edge) begin
              state_n  = LOCKED;
              fclass_n = cand;
              fvalid_n = 1'b1;
              fnew_n   = 1'b1;
            end
          end else begin
            cand_n = in_class;
            cnt_ld = 1'b1;
          end
        end
        LOCKED: begin
`ifdef DECISION_FILTER_HYST_EN
          // cand/run_count follow a challenger; the lock is held.
          if (!sample_ok || in_class == final_class) begin
            cand_n  = NONE;
            cnt_clr = 1'b1;
          end else if (in_class == cand) begin
            cnt_inc = 1'b1;
            if (at_edge) begin
              fclass_n = cand;
              fnew_n   = 1'b1;
            end
          end else begin
            cand_n = in_class;
            cnt_ld = 1'b1;
            if (THR_ONE) begin
              fclass_n = in_class;
              fnew_n   = 1'b1;
            end
          end
`else
          if (!sample_ok) begin
            state_n  = IDLE;
            cand_n   = NONE;
            fclass_n = NONE;
            fvalid_n = 1'b0;
            cnt_clr  = 1'b1;
          end else if (in_class == final_class) begin
            cnt_inc = 1'b1;
          end else begin
            cand_n = in_class;
            cnt_ld = 1'b1;
            if (THR_ONE) begin
              fclass_n = in_class;
              fnew_n   = 1'b1;
            end else begin
              state_n  = TRACK;
              fclass_n = NONE;
              fvalid_n = 1'b0;
            end
          end
`endif
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decision_filter.sv
// Directed bench for decision_filter: default build and a
// THRESHOLD=1 / CNT_W=1 instance driven side by side.
module tb_decision_filter;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       clear = 1'b0;
  logic       in_done = 1'b0;
  logic [2:0] in_class = '0;
  logic [2:0] final_class;
  logic       final_valid;
  logic       final_new;
  logic [3:0] run_count;

  logic       clear1 = 1'b0;
  logic       done1 = 1'b0;
  logic [2:0] class1 = '0;
  logic [2:0] fc1;
  logic       fv1;
  logic       fn1;
  logic [0:0] rc1;

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  decision_filter u_dut (
    .clock      (clock),
    .resetn     (resetn),
    .clear      (clear),
    .in_done    (in_done),
    .in_class   (in_class),
    .final_class(final_class),
    .final_valid(final_valid),
    .final_new  (final_new),
    .run_count  (run_count)
  );

  decision_filter #(
    .THRESHOLD(1),
    .CNT_W    (1)
  ) u_dut1 (
    .clock      (clock),
    .resetn     (resetn),
    .clear      (clear1),
    .in_done    (done1),
    .in_class   (class1),
    .final_class(fc1),
    .final_valid(fv1),
    .final_new  (fn1),
    .run_count  (rc1)
  );

  task automatic push(input logic [2:0] c);
    in_done  = 1'b1;
    in_class = c;
    @(negedge clock);
    in_done  = 1'b0;
    in_class = '0;
  endtask

  task automatic push_n(input logic [2:0] c, input int n);
    for (int i = 0; i < n; i++) push(c);
  endtask

  task automatic push1(input logic [2:0] c);
    done1  = 1'b1;
    class1 = c;
    @(negedge clock);
    done1  = 1'b0;
    class1 = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #3;
    checks++;
    if ({final_class, final_valid, final_new, run_count} !== 9'd0) begin
      fails++;
      $display("FAIL reset_outs actual=%h required=0",
               {final_class, final_valid, final_new, run_count});
    end
    checks++;
    if ({fc1, fv1, fn1, rc1} !== 6'd0) begin
      fails++;
      $display("FAIL reset_outs1 actual=%h required=0",
               {fc1, fv1, fn1, rc1});
    end
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_lock();
    int pulses;
    int exp_cnt;
    push_n(3'd2, 14);
    checks++;
    if (run_count !== 4'd14 || final_valid !== 1'b0) begin
      fails++;
      $display("FAIL lock_pre actual=%0d/%0b required=14/0",
               run_count, final_valid);
    end
    push(3'd2);
    checks++;
    if (final_class !== 3'd2 || final_valid !== 1'b1 ||
        final_new !== 1'b1 || run_count !== 4'd15) begin
      fails++;
      $display("FAIL lock_15th actual=%0d/%0b/%0b/%0d required=2/1/1/15",
               final_class, final_valid, final_new, run_count);
    end
    pulses = 1;
`ifdef DECISION_FILTER_HYST_EN
    exp_cnt = 0;
`else
    exp_cnt = 15;
`endif
    for (int i = 0; i < 5; i++) begin
      push(3'd2);
      if (final_new) pulses++;
      checks++;
      if (run_count !== 4'(exp_cnt) || final_class !== 3'd2) begin
        fails++;
        $display("FAIL lock_hold actual=%0d/%0d required=%0d/2",
                 run_count, final_class, exp_cnt);
      end
    end
    @(negedge clock);
    if (final_new) pulses++;
    checks++;
    if (pulses !== 1) begin
      fails++;
      $display("FAIL lock_pulses actual=%0d required=1", pulses);
    end
  endtask

  task automatic test_mismatch();
    do_clear();
    checks++;
    if ({final_class, final_valid, run_count} !== 8'd0) begin
      fails++;
      $display("FAIL clr_outs actual=%h required=0",
               {final_class, final_valid, run_count});
    end
    push_n(3'd3, 14);
    push(3'd1);
    checks++;
    if (run_count !== 4'd1) begin
      fails++;
      $display("FAIL mis_reload actual=%0d required=1", run_count);
    end
    push_n(3'd3, 14);
    checks++;
    if (run_count !== 4'd14 || final_valid !== 1'b0 ||
        final_class !== 3'd0) begin
      fails++;
      $display("FAIL mis_nodecl actual=%0d/%0b/%0d required=14/0/0",
               run_count, final_valid, final_class);
    end
  endtask

  task automatic test_change();
    do_clear();
    push_n(3'd1, 15);
    checks++;
    if (final_class !== 3'd1 || final_valid !== 1'b1) begin
      fails++;
      $display("FAIL chg_lock actual=%0d/%0b required=1/1",
               final_class, final_valid);
    end
    push(3'd4);
`ifdef DECISION_FILTER_HYST_EN
    push_n(3'd4, 13);
    checks++;
    if (final_class !== 3'd1 || final_valid !== 1'b1 ||
        run_count !== 4'd14) begin
      fails++;
      $display("FAIL chg_hold actual=%0d/%0b/%0d required=1/1/14",
               final_class, final_valid, run_count);
    end
    push(3'd4);
    checks++;
    if (final_class !== 3'd4 || final_new !== 1'b1) begin
      fails++;
      $display("FAIL chg_swap actual=%0d/%0b required=4/1",
               final_class, final_new);
    end
`else
    checks++;
    if (final_valid !== 1'b0 || final_class !== 3'd0 ||
        run_count !== 4'd1 || final_new !== 1'b0) begin
      fails++;
      $display("FAIL chg_drop actual=%0b/%0d/%0d/%0b required=0/0/1/0",
               final_valid, final_class, run_count, final_new);
    end
`endif
  endtask

  task automatic test_invalid();
    do_clear();
    push_n(3'd2, 5);
    push(3'd0);
    checks++;
    if (run_count !== 4'd0 || final_valid !== 1'b0) begin
      fails++;
      $display("FAIL inv_zero actual=%0d required=0", run_count);
    end
    push(3'd2);
    checks++;
    if (run_count !== 4'd1) begin
      fails++;
      $display("FAIL inv_restart actual=%0d required=1", run_count);
    end
    push_n(3'd2, 3);
    push(3'd5);
    checks++;
    if (run_count !== 4'd0) begin
      fails++;
      $display("FAIL inv_five actual=%0d required=0", run_count);
    end
    push_n(3'd2, 15);
    clear = 1'b1;
    push(3'd2);
    clear = 1'b0;
    checks++;
    if ({final_class, final_valid, final_new, run_count} !== 9'd0) begin
      fails++;
      $display("FAIL clr_prio actual=%h required=0",
               {final_class, final_valid, final_new, run_count});
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    push_n(3'd3, 9);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (run_count !== 4'd0) begin
      fails++;
      $display("FAIL areset_cnt actual=%0d required=0", run_count);
    end
    #1;
    resetn = 1'b1;
    @(negedge clock);
    push_n(3'd3, 14);
    checks++;
    if (run_count !== 4'd14 || final_valid !== 1'b0) begin
      fails++;
      $display("FAIL areset_fresh actual=%0d/%0b required=14/0",
               run_count, final_valid);
    end
    push(3'd3);
    checks++;
    if (final_class !== 3'd3 || final_valid !== 1'b1 ||
        final_new !== 1'b1) begin
      fails++;
      $display("FAIL areset_relock actual=%0d/%0b/%0b required=3/1/1",
               final_class, final_valid, final_new);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({final_class, final_valid, final_new, run_count} !== 9'd0) begin
      fails++;
      $display("FAIL areset_lock actual=%h required=0",
               {final_class, final_valid, final_new, run_count});
    end
    #1;
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_thr1();
    push1(3'd2);
    checks++;
    if (fc1 !== 3'd2 || fv1 !== 1'b1 || fn1 !== 1'b1 || rc1 !== 1'b1) begin
      fails++;
      $display("FAIL thr1_first actual=%0d/%0b/%0b/%0d required=2/1/1/1",
               fc1, fv1, fn1, rc1);
    end
    push1(3'd2);
    checks++;
    if (fc1 !== 3'd2 || fn1 !== 1'b0) begin
      fails++;
      $display("FAIL thr1_same actual=%0d/%0b required=2/0", fc1, fn1);
    end
    push1(3'd3);
    checks++;
    if (fc1 !== 3'd3 || fv1 !== 1'b1 || fn1 !== 1'b1) begin
      fails++;
      $display("FAIL thr1_chg3 actual=%0d/%0b/%0b required=3/1/1",
               fc1, fv1, fn1);
    end
    push1(3'd1);
    checks++;
    if (fc1 !== 3'd1 || fn1 !== 1'b1) begin
      fails++;
      $display("FAIL thr1_chg1 actual=%0d/%0b required=1/1", fc1, fn1);
    end
    @(negedge clock);
    checks++;
    if (fn1 !== 1'b0 || fc1 !== 3'd1) begin
      fails++;
      $display("FAIL thr1_idle actual=%0b/%0d required=0/1", fn1, fc1);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_mismatch();
    test_change();
    test_invalid();
    test_async_reset();
    test_thr1();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/decision_filter.md
DECISION_FILTER -- requirements
Module: decision_filter

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 4: number of valid decision classes, codes 1..NUM_CLASSES; code 0 means "no class".
REQ-002 SHALL have parameter THRESHOLD, default 15: number of consecutive matching samples required to declare a class, legal range 1..2^CNT_W-1.
REQ-003 SHALL have parameter CNT_W, default 4: run-counter width.
REQ-004 SHALL derive localparam CLASS_W = clog2(NUM_CLASSES+1).
REQ-005 SHALL provide the following ports, with one clock and an asynchronous, active-low reset:
- clock  in  1  sole clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush to IDLE
- in_done  in  1  sample strobe from detector, one cycle per sample
- in_class  in  CLASS_W  detector decision, qualified by in_done
- final_class  out  CLASS_W  declared class, 0 when none
- final_valid  out  1  level, high while a class is declared
- final_new  out  1  one-cycle pulse on each new or changed declaration
- run_count  out  CNT_W  current consecutive-match count

Function
REQ-006 SHALL treat in_class values 0 or >NUM_CLASSES as invalid samples.
REQ-007 SHALL change state only on cycles with in_done=1 or clear=1.
REQ-008 SHALL implement states IDLE, TRACK and LOCKED.
REQ-009 In IDLE, a valid sample c SHALL load cand=c and run_count=1, then go to TRACK; an invalid sample SHALL leave IDLE unchanged.
REQ-010 In TRACK:
- sample equal to cand: run_count increments;
- different valid sample: cand reloads and run_count=1;
- invalid sample: go to IDLE with run_count=0.
REQ-011 When a matching sample brings run_count to THRESHOLD, the block SHALL, on that same edge, go to LOCKED with final_class=cand, final_valid=1 and final_new=1 for exactly one cycle. Latency is 1 cycle after the THRESHOLD-th in_done.
REQ-012 When THRESHOLD=1, the first valid sample SHALL lock directly from IDLE.
REQ-013 run_count SHALL saturate at THRESHOLD and never wrap.
REQ-014 In LOCKED, further samples matching final_class SHALL keep the lock, with no final_new pulse.
REQ-015 clear SHALL take priority over a simultaneous in_done: the sample is dropped, the state goes to IDLE, and all outputs go to 0.
REQ-016 final_new SHALL be 0 on every cycle not named in REQ-011 or REQ-021.

Reset
REQ-017 While resetn=0, the state SHALL be IDLE and cand, run_count, final_class, final_valid and final_new SHALL all be 0, asynchronously.
REQ-018 A reset mid-TRACK or mid-LOCKED SHALL discard all history; the first sample after release is treated as a new run.

Configuration
REQ-019 Macro DECISION_FILTER_HYST_EN SHALL select the lock-change behaviour described in REQ-020 and REQ-021.
REQ-020 Without DECISION_FILTER_HYST_EN, in LOCKED:
- different valid sample: go to TRACK with cand=new and run_count=1, and drop final_valid and final_class to 0;
- invalid sample: go to IDLE with all outputs 0.
REQ-021 With DECISION_FILTER_HYST_EN, in LOCKED:
- the declaration SHALL be held, and a challenger class SHALL be tracked in cand/run_count;
- a matching or invalid sample SHALL zero the challenger count;
- a challenger reaching THRESHOLD SHALL replace final_class and pulse final_new, staying in LOCKED;
- only clear or reset SHALL drop final_valid.

Structure
REQ-022 Package decision_pkg SHALL hold:
- the state enum {IDLE, TRACK, LOCKED};
- the CLASS_NONE=0 constant;
- the default NUM_CLASSES and THRESHOLD values.
REQ-023 Sub-module sat_counter SHALL implement the saturating counter, with clear, load-1, increment, limit input and CNT_W parameter.
REQ-024 Elaboration SHALL fail when THRESHOLD>2^CNT_W-1 or THRESHOLD=0.

Verification
REQ-025 With defaults, 15 samples of class 2 SHALL give final_class=2, final_valid=1, a single final_new pulse 1 cycle after the 15th in_done, and run_count=15 held through 5 further class-2 samples.
REQ-026 14 samples of class 3, then 1 of class 1, then 14 of class 3 SHALL give no declaration and run_count=14.
REQ-027 Locked on class 1, then one class-4 sample SHALL give:
- without the macro: final_valid=0 and run_count=1;
- with the macro: final_class=1 held until the 15th consecutive class-4 sample, then final_class=4 with a final_new pulse.
REQ-028 in_class=0 or 5 mid-run SHALL go to IDLE (without the macro); clear asserted together with in_done SHALL drop the sample and zero all outputs.
REQ-029 resetn pulsed low mid-TRACK (count=9) SHALL zero outputs immediately, with no clock edge needed; the next 15 samples SHALL re-lock.
REQ-030 With THRESHOLD=1 and CNT_W=1, each class change SHALL lock immediately with one final_new pulse per change.
